// File: rtl/memory_stage.sv
// memory_stage: pipeline Memory stage performing LDW/STW against a word-addressed DMEM.
// Define MEM_MMIO_EN to map byte addresses 0xFxxx onto the LEDR/HEX MMIO block.
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef OPC_LDW
`define OPC_LDW 8'h10
`endif
`ifndef OPC_STW
`define OPC_STW 8'h11
`endif

module memory_stage #(
    parameter int DMEM_ADDR_BITS = 10
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET,
    input  logic                     I_LOCK,
    input  logic [`REG_WIDTH-1:0]    I_ALUOut,
    input  logic [`OPCODE_WIDTH-1:0] I_Opcode,
    input  logic [3:0]               I_DestRegIdx,
    input  logic [`REG_WIDTH-1:0]    I_DestValue,
    input  logic                     I_FetchStall,
    input  logic                     I_DepStall,
    output logic                     O_LOCK,
    output logic [`REG_WIDTH-1:0]    O_ALUOut,
    output logic [`REG_WIDTH-1:0]    O_MemOut,
    output logic [`OPCODE_WIDTH-1:0] O_Opcode,
    output logic [3:0]               O_DestRegIdx,
    output logic                     O_FetchStall,
    output logic                     O_DepStall,
    output logic                     O_MemStall,
    output logic [9:0]               O_LEDR,
    output logic [15:0]              O_HEX,
    output logic                     O_DbgState
);

    localparam logic [`OPCODE_WIDTH-1:0] OP_LDW = `OPC_LDW;
    localparam logic [`OPCODE_WIDTH-1:0] OP_STW = `OPC_STW;

    typedef enum logic {S_IDLE = 1'b0, S_LOAD_WAIT = 1'b1} state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_accept_op;
    logic   w_accept_ld;
    logic   w_do_store;

    logic [DMEM_ADDR_BITS-1:0] w_word_idx;
    logic                      w_is_mmio;
    logic [`REG_WIDTH-1:0]     w_mmio_rdata;

    logic [`REG_WIDTH-1:0]     r_dmem [0:(1<<DMEM_ADDR_BITS)-1];
    logic [`REG_WIDTH-1:0]     r_dmem_rd;

    logic                      r_lock;
    logic [`REG_WIDTH-1:0]     r_alu_out;
    logic [`REG_WIDTH-1:0]     r_mem_out;
    logic [`OPCODE_WIDTH-1:0]  r_opcode;
    logic [3:0]                r_dest_idx;
    logic                      r_fetch_stall;
    logic                      r_dep_stall;
    logic                      r_mem_stall;

    // Copies of the LDW being serviced, replayed to Writeback in LOAD_WAIT.
    logic [`REG_WIDTH-1:0]     r_ld_alu;
    logic [`OPCODE_WIDTH-1:0]  r_ld_opcode;
    logic [3:0]                r_ld_dest_idx;
    logic                      r_ld_fetch_stall;
    logic                      r_ld_dep_stall;
    logic                      r_ld_is_mmio;
    logic [`REG_WIDTH-1:0]     r_ld_mmio_rd;

    assign w_word_idx = I_ALUOut[DMEM_ADDR_BITS+1:2];

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept_op  = 1'b0;
        w_accept_ld  = 1'b0;
        w_do_store   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (I_LOCK && !I_RESET) begin
                    if (I_Opcode == OP_LDW) begin
                        w_accept_ld  = 1'b1;
                        w_next_state = S_LOAD_WAIT;
                    end else begin
                        w_accept_op = 1'b1;
                        w_do_store  = (I_Opcode == OP_STW);
                    end
                end
            end
            S_LOAD_WAIT: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

`ifdef MEM_MMIO_EN
    logic [9:0]  r_ledr;
    logic [15:0] r_hex;

    assign w_is_mmio = (I_ALUOut[15:12] == 4'hF);

    // Offset bits [1:0] are ignored here just as they are for DMEM.
    always_comb begin
        w_mmio_rdata = '0;
        if (I_ALUOut[15:2] == 14'h3C00) begin
            w_mmio_rdata = {{(`REG_WIDTH-10){1'b0}}, r_ledr};
        end else if (I_ALUOut[15:2] == 14'h3C01) begin
            w_mmio_rdata = r_hex;
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            r_ledr <= '0;
            r_hex  <= '0;
        end else if (w_do_store && w_is_mmio) begin
            if (I_ALUOut[15:2] == 14'h3C00) begin
                r_ledr <= I_DestValue[9:0];
            end else if (I_ALUOut[15:2] == 14'h3C01) begin
                r_hex <= I_DestValue[15:0];
            end
        end
    end

    assign O_LEDR = r_ledr;
    assign O_HEX  = r_hex;
`else
    assign w_is_mmio    = 1'b0;
    assign w_mmio_rdata = '0;
    assign O_LEDR       = '0;
    assign O_HEX        = '0;
`endif

    always_ff @(negedge I_CLOCK) begin
        if (w_do_store && !w_is_mmio) begin
            r_dmem[w_word_idx] <= I_DestValue;
        end
        if (w_accept_ld) begin
            r_dmem_rd <= r_dmem[w_word_idx];
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            r_lock           <= 1'b0;
            r_alu_out        <= '0;
            r_mem_out        <= '0;
            r_opcode         <= '0;
            r_dest_idx       <= '0;
            r_fetch_stall    <= 1'b0;
            r_dep_stall      <= 1'b0;
            r_mem_stall      <= 1'b0;
            r_ld_alu         <= '0;
            r_ld_opcode      <= '0;
            r_ld_dest_idx    <= '0;
            r_ld_fetch_stall <= 1'b0;
            r_ld_dep_stall   <= 1'b0;
            r_ld_is_mmio     <= 1'b0;
            r_ld_mmio_rd     <= '0;
        end else if (w_accept_op) begin
            r_lock        <= 1'b1;
            r_alu_out     <= I_ALUOut;
            r_opcode      <= I_Opcode;
            r_dest_idx    <= I_DestRegIdx;
            r_fetch_stall <= I_FetchStall;
            r_dep_stall   <= I_DepStall;
        end else if (w_accept_ld) begin
            r_lock           <= 1'b0;
            r_mem_stall      <= 1'b1;
            r_ld_alu         <= I_ALUOut;
            r_ld_opcode      <= I_Opcode;
            r_ld_dest_idx    <= I_DestRegIdx;
            r_ld_fetch_stall <= I_FetchStall;
            r_ld_dep_stall   <= I_DepStall;
            r_ld_is_mmio     <= w_is_mmio;
            r_ld_mmio_rd     <= w_mmio_rdata;
        end else if (r_state == S_LOAD_WAIT) begin
            r_lock        <= 1'b1;
            r_mem_stall   <= 1'b0;
            r_mem_out     <= r_ld_is_mmio ? r_ld_mmio_rd : r_dmem_rd;
            r_alu_out     <= r_ld_alu;
            r_opcode      <= r_ld_opcode;
            r_dest_idx    <= r_ld_dest_idx;
            r_fetch_stall <= r_ld_fetch_stall;
            r_dep_stall   <= r_ld_dep_stall;
        end else begin
            r_lock <= 1'b0;
        end
    end

    assign O_LOCK       = r_lock;
    assign O_ALUOut     = r_alu_out;
    assign O_MemOut     = r_mem_out;
    assign O_Opcode     = r_opcode;
    assign O_DestRegIdx = r_dest_idx;
    assign O_FetchStall = r_fetch_stall;
    assign O_DepStall   = r_dep_stall;
    assign O_MemStall   = r_mem_stall;
    assign O_DbgState   = r_state;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: passthrough, store/load, load hold, reset mid-load, MMIO.
module tb_memory_stage;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_ADDI = 8'h02;
  localparam logic [7:0] OP_LDW  = 8'h10;
  localparam logic [7:0] OP_STW  = 8'h11;

  logic        clk;
  logic        rst;
  logic        i_lock;
  logic [15:0] i_alu;
  logic [7:0]  i_op;
  logic [3:0]  i_dest;
  logic [15:0] i_val;
  logic        i_fs;
  logic        i_ds;
  logic        o_lock;
  logic [15:0] o_alu;
  logic [15:0] o_mem;
  logic [7:0]  o_op;
  logic [3:0]  o_dest;
  logic        o_fs;
  logic        o_ds;
  logic        o_mstall;
  logic [9:0]  o_ledr;
  logic [15:0] o_hex;
  logic        o_state;

  int n_cmp = 0;
  int n_err = 0;

  memory_stage dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(i_lock), .I_ALUOut(i_alu),
    .I_Opcode(i_op), .I_DestRegIdx(i_dest), .I_DestValue(i_val),
    .I_FetchStall(i_fs), .I_DepStall(i_ds),
    .O_LOCK(o_lock), .O_ALUOut(o_alu), .O_MemOut(o_mem), .O_Opcode(o_op),
    .O_DestRegIdx(o_dest), .O_FetchStall(o_fs), .O_DepStall(o_ds),
    .O_MemStall(o_mstall), .O_LEDR(o_ledr), .O_HEX(o_hex), .O_DbgState(o_state)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // DUT updates on negedge; inputs change and outputs are sampled at posedge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lock, input logic [7:0] op, input logic [15:0] alu,
                       input logic [3:0] dest, input logic [15:0] val,
                       input logic fs, input logic ds);
    i_lock = lock; i_op = op; i_alu = alu; i_dest = dest; i_val = val; i_fs = fs; i_ds = ds;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, OP_ADD, 16'hFFFF, 4'hF, 16'hFFFF, 1'b1, 1'b1);
    @(posedge clk);
    #1;

    // Reset
    tick();
    check("rst_lock", o_lock, 0);
    check("rst_alu", o_alu, 0);
    check("rst_mem", o_mem, 0);
    check("rst_op", o_op, 0);
    check("rst_dest", o_dest, 0);
    check("rst_fs_ds", {o_fs, o_ds}, 0);
    check("rst_mstall", o_mstall, 0);
    check("rst_leds_hex", {o_ledr, o_hex}, 0);
    check("rst_state", o_state, 0);

    // ADD passthrough
    rst = 1'b0;
    drive(1'b1, OP_ADD, 16'h1234, 4'd5, 16'h0000, 1'b1, 1'b0);
    tick();
    check("add_lock", o_lock, 1);
    check("add_alu", o_alu, 16'h1234);
    check("add_dest", o_dest, 5);
    check("add_op", o_op, OP_ADD);
    check("add_fs_ds", {o_fs, o_ds}, 2'b10);
    check("add_mstall", o_mstall, 0);

    // Idle bubble: O_LOCK drops, others hold
    drive(1'b0, OP_ADD, 16'h5555, 4'd9, 16'h0000, 1'b0, 1'b1);
    tick();
    check("idle_lock", o_lock, 0);
    check("idle_alu_hold", o_alu, 16'h1234);

    // STW 0x0010 <- 0xBEEF
    drive(1'b1, OP_STW, 16'h0010, 4'd0, 16'hBEEF, 1'b0, 1'b0);
    tick();
    check("stw_lock", o_lock, 1);
    check("stw_op", o_op, OP_STW);
    check("stw_alu", o_alu, 16'h0010);

    // LDW 0x0012 (same word), then ADDI held across the stall
    drive(1'b1, OP_LDW, 16'h0012, 4'd3, 16'h0000, 1'b0, 1'b1);
    tick();
    check("ld1_bubble", o_lock, 0);
    check("ld1_mstall", o_mstall, 1);
    check("ld1_state", o_state, 1);
    drive(1'b1, OP_ADDI, 16'h0007, 4'd6, 16'h0000, 1'b0, 1'b0);
    tick();
    check("ld1_lock", o_lock, 1);
    check("ld1_memout", o_mem, 16'hBEEF);
    check("ld1_alu", o_alu, 16'h0012);
    check("ld1_op", o_op, OP_LDW);
    check("ld1_dest", o_dest, 3);
    check("ld1_ds", o_ds, 1);
    check("ld1_mstall_clr", o_mstall, 0);
    check("ld1_state_idle", o_state, 0);
    tick();
    check("addi_lock", o_lock, 1);
    check("addi_alu", o_alu, 16'h0007);
    check("addi_op", o_op, OP_ADDI);
    check("addi_dest", o_dest, 6);
    check("addi_memout_hold", o_mem, 16'hBEEF);
    drive(1'b0, OP_ADD, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b0);
    tick();
    check("addi_once", o_lock, 0);

    // Second word, then back-to-back loads including an aliased address
    drive(1'b1, OP_STW, 16'h0020, 4'd0, 16'h1111, 1'b0, 1'b0);
    tick();
    drive(1'b1, OP_LDW, 16'h0020, 4'd1, 16'h0000, 1'b0, 1'b0);
    tick();
    check("b2b_a_stall", o_mstall, 1);
    drive(1'b1, OP_LDW, 16'h1010, 4'd2, 16'h0000, 1'b0, 1'b0);
    tick();
    check("b2b_a_mem", o_mem, 16'h1111);
    check("b2b_a_dest", o_dest, 1);
    tick();
    check("b2b_b_bubble", o_lock, 0);
    check("b2b_b_stall", o_mstall, 1);
    drive(1'b0, OP_ADD, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b0);
    tick();
    check("b2b_b_lock", o_lock, 1);
    check("b2b_b_mem_alias", o_mem, 16'hBEEF);
    check("b2b_b_alu", o_alu, 16'h1010);

    // Reset during LOAD_WAIT
    drive(1'b1, OP_LDW, 16'h0020, 4'd7, 16'h0000, 1'b0, 1'b0);
    tick();
    check("rml_stall", o_mstall, 1);
    rst = 1'b1;
    tick();
    check("rml_lock", o_lock, 0);
    check("rml_mem", o_mem, 0);
    check("rml_mstall", o_mstall, 0);
    check("rml_state", o_state, 0);
    rst = 1'b0;
    drive(1'b0, OP_ADD, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b0);
    tick();
    check("rml_no_result", o_lock, 0);
    check("rml_mem_stays", o_mem, 0);

    // Word 0 setup, then 0xF000 access
    drive(1'b1, OP_STW, 16'h0000, 4'd0, 16'hA5A5, 1'b0, 1'b0);
    tick();
    drive(1'b1, OP_STW, 16'hF000, 4'd0, 16'h03FF, 1'b0, 1'b0);
    tick();
`ifdef MEM_MMIO_EN
    check("mmio_ledr", o_ledr, 10'h3FF);
    drive(1'b1, OP_LDW, 16'hF000, 4'd4, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    check("mmio_ld_ledr", o_mem, 16'h03FF);
    drive(1'b1, OP_LDW, 16'h0000, 4'd4, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    check("mmio_dmem0_kept", o_mem, 16'hA5A5);
    drive(1'b1, OP_STW, 16'hF004, 4'd0, 16'hC0DE, 1'b0, 1'b0);
    tick();
    check("mmio_hex", o_hex, 16'hC0DE);
    drive(1'b1, OP_LDW, 16'hF004, 4'd4, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    check("mmio_ld_hex", o_mem, 16'hC0DE);
    drive(1'b1, OP_LDW, 16'hF008, 4'd4, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    check("mmio_ld_other", o_mem, 16'h0000);
`else
    check("nommio_ledr", o_ledr, 0);
    check("nommio_hex", o_hex, 0);
    drive(1'b1, OP_LDW, 16'h0000, 4'd4, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    check("nommio_f000_in_dmem", o_mem, 16'h03FF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
